// File: rtl/e1_rx_mf_buf.sv
// E1 receive multiframe buffer: writes timeslot bytes into a ring of multiframe
// slots in external RAM and tracks completed multiframes for a downstream reader.
module e1_rx_mf_buf #(
  parameter int unsigned MFW        = 7,
  parameter int unsigned SLOTS_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            buf_rx_data,
  input  logic [4:0]            buf_rx_ts,
  input  logic [3:0]            buf_rx_frame,
  input  logic [MFW-1:0]        buf_rx_mf,
  input  logic                  buf_rx_we,
  output logic                  buf_rx_rdy,
  output logic [SLOTS_LOG2+8:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic [SLOTS_LOG2:0]   mf_avail,
  output logic [SLOTS_LOG2-1:0] mf_rd_slot,
  output logic [MFW-1:0]        mf_rd_num,
  input  logic                  mf_release,
  output logic                  err_ovf,
  output logic                  err_sync,
  input  logic                  err_clr
);

  localparam int unsigned SLOTS = 1 << SLOTS_LOG2;
  localparam int unsigned ADDRW = SLOTS_LOG2 + 9;
  localparam int unsigned CNTW  = SLOTS_LOG2 + 1;

  localparam logic [CNTW-1:0]       CNT_FULL = CNTW'(SLOTS);
  localparam logic [CNTW-1:0]       CNT_ONE  = CNTW'(1);
  localparam logic [SLOTS_LOG2-1:0] PTR_ONE  = SLOTS_LOG2'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SLOTS_LOG2-1:0] r_wr_ptr;
  logic [SLOTS_LOG2-1:0] r_rd_ptr;
  logic [CNTW-1:0]       r_count;
  logic [CNTW-1:0]       w_count_nxt;
  logic [MFW-1:0]        r_desc [SLOTS];
  logic [ADDRW-1:0]      r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_rdy;
  logic                  r_err_ovf;
  logic                  r_err_sync;

  logic w_full;
  logic w_is_first;
  logic w_is_last;
  logic w_wr;
  logic w_capture;
  logic w_complete;
  logic w_ovf_set;
  logic w_sync_set;
  logic w_release;

  assign w_full     = (r_count == CNT_FULL);
  assign w_is_first = (buf_rx_frame == 4'd0)  && (buf_rx_ts == 5'd0);
  assign w_is_last  = (buf_rx_frame == 4'd15) && (buf_rx_ts == 5'd31);
  assign w_release  = mf_release && (r_count != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-write actions
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    w_ovf_set   = 1'b0;
    w_sync_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (buf_rx_we) begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else if (w_is_first) begin
            w_wr        = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (buf_rx_we) begin
          w_wr = 1'b1;
          if (w_is_first) begin
            w_capture  = 1'b1;
            w_sync_set = 1'b1;
          end else if (w_is_last) begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Completion and release in the same cycle cancel in the count
  always_comb begin
    w_count_nxt = r_count;
    if (w_complete && !w_release) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_complete && w_release) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rdy       <= 1'b1;
      r_err_ovf   <= 1'b0;
      r_err_sync  <= 1'b0;
    end else begin
      r_mem_we <= w_wr;
      if (w_wr) begin
        r_mem_addr  <= {r_wr_ptr, buf_rx_frame, buf_rx_ts};
        r_mem_wdata <= buf_rx_data;
      end
      if (w_complete) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_release) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count    <= w_count_nxt;
      r_rdy      <= (w_count_nxt != CNT_FULL);
      r_err_ovf  <= w_ovf_set  || (r_err_ovf  && !err_clr);
      r_err_sync <= w_sync_set || (r_err_sync && !err_clr);
    end
  end

  // Descriptor storage carries no reset; only written slots are ever read
  always_ff @(posedge clk) begin
    if (w_capture && !rst) begin
      r_desc[r_wr_ptr] <= buf_rx_mf;
    end
  end

  assign buf_rx_rdy = r_rdy;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign mf_avail   = r_count;
  assign mf_rd_slot = r_rd_ptr;
  assign mf_rd_num  = r_desc[r_rd_ptr];
  assign err_ovf    = r_err_ovf;
  assign err_sync   = r_err_sync;

endmodule

// File: doc/e1_rx_mf_buf.md
E1_RX_MF_BUF -- requirements
Module: e1_rx_mf_buf

Interface
REQ-001 Parameter MFW, default 7: width of the multiframe number on buf_rx_mf.
REQ-002 Parameter SLOTS_LOG2, default 2: log2 of the number of multiframe slots in the ring (4 slots).
REQ-003 Port clk  in  1: the single clock, rising edge.
REQ-004 Port rst  in  1: reset, synchronous and active-high.
REQ-005 Port buf_rx_data  in  8: received timeslot byte.
REQ-006 Port buf_rx_ts  in  5: timeslot index (0..31).
REQ-007 Port buf_rx_frame  in  4: frame index within the multiframe (0..15).
REQ-008 Port buf_rx_mf  in  MFW: multiframe number.
REQ-009 Port buf_rx_we  in  1: byte write strobe.
REQ-010 Port buf_rx_rdy  out  1: slot space available.
REQ-011 Port mem_addr  out  SLOTS_LOG2+9: RAM write address, {slot, frame, ts}.
REQ-012 Port mem_wdata  out  8: RAM write data.
REQ-013 Port mem_we  out  1: RAM write enable.
REQ-014 Port mf_avail  out  SLOTS_LOG2+1: number of completed multiframes not yet released.
REQ-015 Port mf_rd_slot  out  SLOTS_LOG2: slot index of the oldest completed multiframe.
REQ-016 Port mf_rd_num  out  MFW: multiframe number captured for slot mf_rd_slot.
REQ-017 Port mf_release  in  1: single-cycle pulse that frees the oldest completed slot.
REQ-018 Port err_ovf  out  1: sticky flag, a write arrived while the ring was full.
REQ-019 Port err_sync  out  1: sticky flag, a multiframe restarted before completing.
REQ-020 Port err_clr  in  1: clears both sticky error flags.

Function
REQ-021 State machine states: IDLE (waiting for a multiframe start) and FILL (writing the slot at wr_ptr).
REQ-022 IDLE: a write with frame=0 and ts=0, while the ring is not full, moves to FILL, writes to slot wr_ptr, and captures buf_rx_mf into the descriptor for wr_ptr.
REQ-023 IDLE: any other write is dropped (no mem_we) and sets no flag.
REQ-024 FILL: every write produces mem_we with mem_addr={wr_ptr, frame, ts}.
REQ-025 FILL: a write with frame=15 and ts=31 completes the slot: wr_ptr increments modulo 2^SLOTS_LOG2, count increments, next state IDLE.
REQ-026 FILL: a write with frame=0 and ts=0 restarts the same slot, recaptures mf, sets err_sync, and stays in FILL.
REQ-027 Memory write latency: mem_addr, mem_wdata and mem_we are registered, so a strobe at cycle N gives mem_we at cycle N+1; mem_we is otherwise 0.
REQ-028 Full is count == 2^SLOTS_LOG2; buf_rx_rdy = ~full, registered from the next-state count.
REQ-029 Full in IDLE: a write is dropped and sets err_ovf.
REQ-030 mf_release with count>0: rd_ptr increments modulo 2^SLOTS_LOG2 and count decrements; mf_release with count=0 is ignored.
REQ-031 A completion and a release in the same cycle leave count unchanged; both pointers advance.
REQ-032 Completing into the last free slot makes buf_rx_rdy 0 on the next cycle; a release while full makes buf_rx_rdy 1 on the next cycle.
REQ-033 mf_avail = count; mf_rd_slot = rd_ptr; mf_rd_num = descriptor[rd_ptr]; all are valid combinationally from the registered state.
REQ-034 If err_clr and a new error event occur in the same cycle, the flag is set (set wins).
REQ-035 Pointers wrap modulo 2^SLOTS_LOG2 with no extra state; count ranges 0..2^SLOTS_LOG2.

Reset
REQ-036 On rst: state is IDLE; wr_ptr, rd_ptr and count are 0; err_ovf, err_sync and mem_we are 0; buf_rx_rdy is 1.
REQ-037 On rst: descriptor contents are don't-care.
REQ-038 rst during FILL abandons the partial slot; no completion is counted.

Verification
REQ-039 Full multiframe: 512 writes (frame 0..15, ts 0..31), mf=5 -> 512 mem_we with addresses 0x000..0x1FF, mf_avail=1, mf_rd_num=5, mf_rd_slot=0.
REQ-040 Fill to full: 4 complete multiframes with no release -> buf_rx_rdy=0; a 5th write at (0,0) -> no mem_we, err_ovf=1; one mf_release -> buf_rx_rdy=1, mf_avail=3, mf_rd_slot=1.
REQ-041 Restart: start a multiframe, write 100 bytes, then write (0,0) with mf=9 -> err_sync=1, the slot is rewritten from address {0,0,0}, and the captured mf is 9 after completion.
REQ-042 Simultaneous events: with mf_avail=2, a completion in the same cycle as mf_release -> mf_avail stays 2, wr_ptr and rd_ptr both advance; mf_release at mf_avail=0 -> no change.
REQ-043 Wrap and recovery: 6 multiframes with a release after each completion -> slots used 0,1,2,3,0,1 and mf_rd_num tracks input; writes with nonzero frame/ts in IDLE -> no mem_we; rst mid-FILL -> mf_avail=0, buf_rx_rdy=1.
